// File: rtl/data_ram_pkg.sv
// Shared encodings and lane helpers for the byte-addressable data scratchpad.
package data_ram_pkg;

  localparam logic [1:0] HB_BYTE = 2'b00;
  localparam logic [1:0] HB_HALF = 2'b01;
  localparam logic [1:0] HB_WORD = 2'b10;
  localparam logic [1:0] HB_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_ACCESS = 3'b010,
    ST_RESP   = 3'b100
  } state_e;

  function automatic logic [3:0] lane_mask(input logic [1:0] hb, input logic [1:0] a);
    logic [3:0] m;
    case (hb)
      HB_BYTE: m = 4'b0001 << a;
      HB_HALF: m = a[1] ? 4'b1100 : 4'b0011;
      HB_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Replicate right-aligned store data across every lane it could land in.
  function automatic logic [31:0] store_data(input logic [1:0] hb, input logic [31:0] wdata);
    logic [31:0] d;
    case (hb)
      HB_BYTE: d = {4{wdata[7:0]}};
      HB_HALF: d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] hb,
                                              input logic [1:0] a, input logic uload);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = a[1] ? word[31:16] : word[15:0];
    case (hb)
      HB_BYTE: r = {(uload ? 24'd0 : {24{b[7]}}), b};
      HB_HALF: r = {(uload ? 16'd0 : {16{h[15]}}), h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_ram_array.sv
// DEPTH x 32 block RAM with byte write mask and registered read; contents survive reset.
module data_ram_array #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] INIT_WORD = 32'hCACACACA,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  (* ram_style = "block" *) logic [31:0] mem_q [DEPTH] = '{default: INIT_WORD};
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < 4; i++) begin
          if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_ram.sv
// Load/store bus scratchpad: req/gnt FSM, request latches, error decode, output registers.
// Optional: define DATA_RAM_ERR_EN to report faulty accesses on err_o.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] INIT_WORD = 32'hCACACACA
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ce_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [1:0]  hb_i,
  input  logic        uload_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  hb_q, hb_d;
  logic        uload_q, uload_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        gnt_q, gnt_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic          fault_c;
  logic          accept_c;
  logic          wr_en_c;
  logic [AW-1:0] ram_addr_c;
  logic [31:0]   ram_rdata;

  assign accept_c = (state_q == ST_IDLE) && req_i && ce_i;

  // Address bits above the word index must be zero for an in-range access.
  assign fault_c = (hb_q == HB_ILL)
                || ((hb_q == HB_WORD) && (addr_q[1:0] != 2'b00))
                || ((hb_q == HB_HALF) && addr_q[0])
                || ((addr_q[31:2] >> AW) != 30'd0);

  // Loads read the array on the accept edge; stores write on the ACCESS edge.
  assign wr_en_c    = (state_q == ST_ACCESS) && we_q && !fault_c;
  assign ram_addr_c = wr_en_c ? addr_q[AW+1:2] : addr_i[AW+1:2];

  data_ram_array #(
    .DEPTH     (DEPTH),
    .INIT_WORD (INIT_WORD)
  ) u_array (
    .clk_i   (clk_i),
    .en_i    (accept_c || wr_en_c),
    .we_i    (wr_en_c),
    .be_i    (lane_mask(hb_q, addr_q[1:0])),
    .addr_i  (ram_addr_c),
    .wdata_i (store_data(hb_q, wdata_q)),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    hb_d    = hb_q;
    uload_d = uload_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    gnt_d   = 1'b0;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = ST_ACCESS;
          we_d    = we_i;
          hb_d    = hb_i;
          uload_d = uload_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        gnt_d   = 1'b1;
`ifdef DATA_RAM_ERR_EN
        err_d   = fault_c;
`else
        err_d   = 1'b0;
`endif
        rdata_d = (fault_c || we_q) ? 32'd0
                                    : load_extend(ram_rdata, hb_q, addr_q[1:0], uload_q);
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      hb_q    <= HB_BYTE;
      uload_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      gnt_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      hb_q    <= hb_d;
      uload_q <= uload_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_data_ram.sv
// Directed plus randomized checks of data_ram against a byte-level memory model.
module tb_data_ram;

  localparam int unsigned DEPTH     = 64;
  localparam logic [31:0] INIT_WORD = 32'hCACACACA;
`ifdef DATA_RAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        ce_i, req_i, we_i, uload_i;
  logic [1:0]  hb_i;
  logic [31:0] addr_i, wdata_i;
  logic        gnt_o, err_o;
  logic [31:0] rdata_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [DEPTH*4];

  always #5 clk = ~clk;

  data_ram #(.DEPTH(DEPTH), .INIT_WORD(INIT_WORD)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .ce_i(ce_i), .req_i(req_i), .gnt_o(gnt_o),
    .we_i(we_i), .hb_i(hb_i), .uload_i(uload_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .err_o(err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned size_of(input logic [1:0] hb);
    case (hb)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_bad(input logic [1:0] hb, input logic [31:0] a);
    int unsigned n = size_of(hb);
    if (n == 0) return 1'b1;
    if ((a % n) != 0) return 1'b1;
    return (a / 4) >= DEPTH;
  endfunction

  // Model: apply a store byte by byte, or assemble and extend a load.
  task automatic model(input logic we, input logic [1:0] hb, input logic u, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] exp_r, output logic exp_e);
    int unsigned n = size_of(hb);
    logic [31:0] v = 32'd0;
    bit bad = is_bad(hb, a);
    exp_e = ERR_EN && bad;
    exp_r = 32'd0;
    if (bad) return;
    if (we) begin
      for (int k = 0; k < int'(n); k++) ref_mem[a + k] = wd[8*k +: 8];
    end else begin
      for (int k = 0; k < int'(n); k++) v[8*k +: 8] = ref_mem[a + k];
      if (n < 4 && !u && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
      exp_r = v;
    end
  endtask

  task automatic do_access(input string tag, input logic we, input logic [1:0] hb, input logic u,
                           input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
    logic [31:0] exp_r;
    logic        exp_e;
    model(we, hb, u, a, wd, exp_r, exp_e);
    @(negedge clk);
    we_i = we; hb_i = hb; uload_i = u; addr_i = a; wdata_i = wd; ce_i = 1'b1; req_i = 1'b1;
    @(negedge clk);
    check({tag, ".gnt_early"}, 32'(gnt_o), 32'd0);
    @(negedge clk);
    check({tag, ".gnt"}, 32'(gnt_o), 32'd1);
    check({tag, ".rdata"}, rdata_o, exp_r);
    check({tag, ".err"}, 32'(err_o), 32'(exp_e));
    got = rdata_o;
    req_i = 1'b0;
    @(negedge clk);
    check({tag, ".gnt_drop"}, 32'(gnt_o), 32'd0);
    check({tag, ".rdata_hold"}, rdata_o, exp_r);
  endtask

  initial begin
    logic [31:0] r;
    int          grants;
    int          first_g, second_g;

    for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = INIT_WORD[8*(i%4) +: 8];
    rst_ni = 1'b0; ce_i = 1'b0; req_i = 1'b0; we_i = 1'b0; hb_i = 2'b00;
    uload_i = 1'b0; addr_i = 32'd0; wdata_i = 32'd0;
    #1;
    check("rst.gnt", 32'(gnt_o), 32'd0);
    check("rst.err", 32'(err_o), 32'd0);
    check("rst.rdata", rdata_o, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_ni = 1'b1;

    do_access("w_st", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, r);
    do_access("w_ld", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r);
    check("w_ld.const", r, 32'hDEADBEEF);

    do_access("b_st", 1'b1, 2'b00, 1'b0, 32'h13, 32'h00000080, r);
    do_access("b_lds", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, r);
    check("b_lds.const", r, 32'hFFFFFF80);
    do_access("b_ldu", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, r);
    check("b_ldu.const", r, 32'h00000080);
    do_access("b_w", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r);
    check("b_w.const", r, 32'h80ADBEEF);

    do_access("h_st", 1'b1, 2'b01, 1'b0, 32'h12, 32'h00008001, r);
    do_access("h_lds", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, r);
    check("h_lds.const", r, 32'hFFFF8001);
    do_access("h_w", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r);
    check("h_w.const", r, 32'h8001BEEF);

    do_access("mis_st", 1'b1, 2'b10, 1'b0, 32'h11, 32'h11111111, r);
    do_access("mis_w", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r);
    check("mis_w.const", r, 32'h8001BEEF);

    do_access("oor_ld", 1'b0, 2'b10, 1'b0, DEPTH*4, 32'h0, r);
    do_access("ill_ld", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, r);

    // Request held for six cycles: accepted, then re-accepted once FSM is back in IDLE.
    @(negedge clk);
    we_i = 1'b0; hb_i = 2'b10; uload_i = 1'b0; addr_i = 32'h10; ce_i = 1'b1; req_i = 1'b1;
    grants = 0; first_g = -1; second_g = -1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (gnt_o) begin
        grants++;
        if (first_g < 0) first_g = c; else second_g = c;
      end
    end
    req_i = 1'b0;
    check("held.grants", 32'(grants), 32'd2);
    check("held.spacing", 32'(second_g - first_g), 32'd3);
    @(negedge clk); @(negedge clk);

    // Chip enable low: no response at all.
    ce_i = 1'b0; req_i = 1'b1;
    grants = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (gnt_o) grants++;
    end
    req_i = 1'b0;
    check("ce_off.grants", 32'(grants), 32'd0);

    // Reset during ACCESS aborts the store and the grant.
    @(negedge clk);
    we_i = 1'b1; hb_i = 2'b10; addr_i = 32'h20; wdata_i = 32'h12345678; ce_i = 1'b1; req_i = 1'b1;
    @(negedge clk);
    rst_ni = 1'b0; req_i = 1'b0;
    #1;
    check("rst_acc.gnt", 32'(gnt_o), 32'd0);
    check("rst_acc.rdata", rdata_o, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    grants = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (gnt_o) grants++;
    end
    check("rst_acc.nogrant", 32'(grants), 32'd0);
    do_access("rst_ld", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, r);
    check("rst_ld.const", r, INIT_WORD);

    // Reset during RESP drops the grant immediately.
    @(negedge clk);
    we_i = 1'b0; hb_i = 2'b10; addr_i = 32'h10; ce_i = 1'b1; req_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    req_i = 1'b0;
    check("rst_resp.gnt_before", 32'(gnt_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("rst_resp.gnt_after", 32'(gnt_o), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;

    for (int t = 0; t < 150; t++) begin
      logic        we;
      logic [1:0]  hb;
      logic [31:0] a;
      we = 1'($urandom_range(0, 1));
      hb = 2'($urandom_range(0, 3));
      a  = $urandom_range(0, DEPTH*4 + 15);
      if ($urandom_range(0, 3) != 0 && hb != 2'b11) a = a & ~(size_of(hb) - 1);
      do_access("rnd", we, hb, 1'($urandom_range(0, 1)), a, $urandom, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
